lighthouse_sample_arbiter: RTL and testbench
============================================

// Module: lighthouse_sample_arbiter
// PURPOSE
//  Sits downstream of the per-sensor lighthouse decoders. Watches every sensor's
//  32-bit combined_data word and detects each new value. Grants one pending sensor
//  per cycle, round-robin, into a FIFO. Emits {sensor_id, word} records on a
//  valid/ready stream for the host link serializer.
// PARAMETERS
//  NUMBER_OF_SENSORS  20  sensors watched (>=1)
//  FIFO_DEPTH         16  record FIFO entries (power of 2, >=2)
//  ID_W               10  width of the sensor id field (>= clog2(NUMBER_OF_SENSORS))
// PORTS
//  clk          in   1                      single clock; all logic rising-edge
//  rst          in   1                      synchronous, active-high reset
//  sensor_data  in   32*NUMBER_OF_SENSORS   word of sensor i at [32*i+31:32*i]
//  m_valid      out  1                      record available at FIFO head
//  m_ready      in   1                      consumer accepts head when m_valid && m_ready
//  m_id         out  ID_W                   sensor index of head record
//  m_data       out  32                     sensor word of head record
//  fifo_level   out  clog2(FIFO_DEPTH)+1    entries currently stored
//  overwrite_o  out  1                      1-cycle pulse: a pending sample was superseded
// BEHAVIOUR
//  - Reset (rst=1 at an edge): pending[]=0, last_word[]=0, rr_ptr=0, FIFO empty.
//    Outputs: m_valid=0, m_id=0, m_data=0, fifo_level=0, overwrite_o=0.
//    The FIFO contents are discarded, including mid-transfer.
//  - Change detect, per sensor i, each edge:
//    - last_word[i] <= sensor_data[i].
//    - Set pending[i] when sensor_data[i] != last_word[i].
//    - A nonzero word present right after reset therefore produces one record.
//  - Superseded sample: if pending[i] is already 1, is not granted this cycle, and
//    the word changes again, pending[i] stays 1 and overwrite_o pulses for 1 cycle.
//    Only the newest word is kept; the record carries last_word[i] at grant time.
//  - Grant:
//    - When fifo_level < FIFO_DEPTH at cycle start and any pending bit is set,
//      grant the first pending index searching from rr_ptr upward, wrapping mod N.
//    - Write {k, last_word[k]}; clear pending[k]; rr_ptr <= (k+1) mod N.
//    - If pending[k] is re-set by a change in the same cycle, the set wins.
//  - Full: no grants; pending bits hold; nothing is lost except by overwrite.
//  - Latency:
//    - New word stable before edge E0: pending set at E0, record written at E1,
//      m_valid=1 after E1 if the FIFO was empty.
//    - Minimum 2 cycles from input change to m_valid.
//  - FIFO is first-word-fall-through: m_id/m_data show the head whenever m_valid=1.
//    m_id/m_data hold their last value when the FIFO is empty.
//  - Push and pop in the same cycle: fifo_level is unchanged. Push is still gated
//    by the start-of-cycle level, so no push when full even if a pop occurs.
//  - m_ready while m_valid=0 is ignored; the pointers never underflow.
//  - Throughput: 1 record/cycle in and out. All N sensors changing together yields
//    N records on consecutive cycles, given space in the FIFO.
// CONFIGURATION
//  SAMPLE_TIMESTAMP_EN:
//  - Defined: a free-running 32-bit cycle counter (0 at reset, wraps) is captured
//    at change detect into ts[i] and stored with the record.
//  - Adds output port m_ts[31:0], valid with m_valid.
//  - On overwrite, ts[i] updates to the newer change.
//  - Undefined: no counter, no m_ts port, no timestamp storage.
// TESTING  (N=4, FIFO_DEPTH=4)
//  1. Reset, sensor_data all 0 for 10 cycles -> m_valid stays 0, fifo_level 0.
//  2. Sensor 2 word 0 -> 0x0001_2345 -> 2 cycles later m_valid=1, m_id=2,
//     m_data=0x00012345. m_ready=1 -> fifo_level returns to 0.
//  3. All 4 words change in one cycle, m_ready=0 -> records written on 4
//     consecutive cycles, ids 0,1,2,3; fifo_level reaches 4.
//  4. FIFO full (test 3), sensor 1 changes twice more -> overwrite_o pulses once.
//     Pop one record -> next record is id 1 with the newest word.
//  5. Sensor 3 granted, then sensors 0 and 3 pending together -> sensor 0 granted
//     first (rr_ptr wrapped to 0).
//  6. rst asserted with fifo_level=3 while m_ready=1 -> next cycle m_valid=0,
//     fifo_level=0, no record popped twice.
//  7. SAMPLE_TIMESTAMP_EN, change at counter value 100 -> m_ts=100 on that record.

Source files
------------

// File: rtl/lighthouse_sample_arbiter_if.sv
// ---------------------------------------------------------------------------
// lighthouse_sample_arbiter_if
//   Record stream from the sample arbiter to the host link serializer.
//
//   Handshake: the source holds m_valid/m_id/m_data (and m_ts when built with
//   timestamps) stable while m_valid=1. A record transfers on a rising edge
//   where m_valid && m_ready. m_ready while m_valid=0 has no effect.
//
//   Signals
//     m_valid     source -> sink  record available at FIFO head
//     m_ready     sink -> source  sink accepts the head record
//     m_id        source -> sink  sensor index of head record (ID_W bits)
//     m_data      source -> sink  sensor word of head record
//     fifo_level  source -> sink  records currently stored (LEVEL_W bits)
//     overwrite_o source -> sink  1-cycle pulse, a pending sample was superseded
//     m_ts        source -> sink  capture timestamp (SAMPLE_TIMESTAMP_EN only)
//
//   Build option: define SAMPLE_TIMESTAMP_EN to add m_ts.
// ---------------------------------------------------------------------------
interface lighthouse_sample_arbiter_if #(
  parameter int ID_W    = 10,
  parameter int LEVEL_W = 5
);
  logic               m_valid;
  logic               m_ready;
  logic [ID_W-1:0]    m_id;
  logic [31:0]        m_data;
  logic [LEVEL_W-1:0] fifo_level;
  logic               overwrite_o;
`ifdef SAMPLE_TIMESTAMP_EN
  logic [31:0]        m_ts;

  modport master (output m_valid, m_id, m_data, fifo_level, overwrite_o, m_ts,
                  input  m_ready);
  modport slave  (input  m_valid, m_id, m_data, fifo_level, overwrite_o, m_ts,
                  output m_ready);
`else
  modport master (output m_valid, m_id, m_data, fifo_level, overwrite_o,
                  input  m_ready);
  modport slave  (input  m_valid, m_id, m_data, fifo_level, overwrite_o,
                  output m_ready);
`endif
endinterface

// File: rtl/lighthouse_sample_arbiter.sv
// ---------------------------------------------------------------------------
// lighthouse_sample_arbiter
//   Watches every sensor's 32-bit word, flags each new value as pending,
//   grants one pending sensor per cycle (round-robin) into a first-word-
//   fall-through FIFO and streams {sensor_id, word} records out.
//
//   Ports
//     clk          single clock, rising edge
//     rst          synchronous active-high reset
//     sensor_data  32*NUMBER_OF_SENSORS, word i at [32*i+31:32*i]
//     m            lighthouse_sample_arbiter_if.master record stream
//
//   Build option: SAMPLE_TIMESTAMP_EN adds a free-running cycle counter whose
//   value at change detect travels with the record on m.m_ts.
// ---------------------------------------------------------------------------
module lighthouse_sample_arbiter #(
  parameter int NUMBER_OF_SENSORS = 20,
  parameter int FIFO_DEPTH        = 16,
  parameter int ID_W              = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [32*NUMBER_OF_SENSORS-1:0] sensor_data,
  lighthouse_sample_arbiter_if.master    m
);

  localparam int N       = NUMBER_OF_SENSORS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int RR_W    = (N > 1) ? $clog2(N) : 1;
`ifdef SAMPLE_TIMESTAMP_EN
  localparam int REC_W   = ID_W + 64;
`else
  localparam int REC_W   = ID_W + 32;
`endif

  logic [31:0]        last_word [N];
  logic [N-1:0]       pending;
  logic [N-1:0]       changed;
  logic [RR_W-1:0]    rr_ptr;

  logic [REC_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] level_next;

  logic               grant_any;
  logic [RR_W-1:0]    grant_idx;
  logic [RR_W:0]      grant_sum;
  logic [2*N-1:0]     pend_rot;
  logic [N-1:0]       grant_mask;
  logic               push;
  logic               pop;
  logic               overwrite_any;
  logic [REC_W-1:0]   push_rec;
  logic [REC_W-1:0]   head_next;
  logic               head_load;

`ifdef SAMPLE_TIMESTAMP_EN
  logic [31:0]        ts_cnt;
  logic [31:0]        ts [N];
`endif

  // A sensor changes whenever its input differs from the word seen last edge.
  always_comb begin
    changed = '0;
    for (int i = 0; i < N; i++) begin
      changed[i] = (sensor_data[32*i +: 32] != last_word[i]);
    end
  end

  // Round-robin search: rotate pending so rr_ptr lands at bit 0, take the
  // lowest set bit, then map the offset back to a sensor index mod N.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_sum = '0;
    pend_rot  = {pending, pending} >> rr_ptr;
    for (int j = 0; j < N; j++) begin
      if (!grant_any && pend_rot[j]) begin
        grant_any = 1'b1;
        grant_sum = {1'b0, rr_ptr} + (RR_W+1)'(j);
        if (grant_sum >= (RR_W+1)'(N)) grant_sum = grant_sum - (RR_W+1)'(N);
        grant_idx = grant_sum[RR_W-1:0];
      end
    end
  end

  // Push is gated by the start-of-cycle level only; a same-cycle pop does not
  // open a slot for a grant.
  assign push       = grant_any && (level != LEVEL_W'(FIFO_DEPTH));
  assign pop        = (level != '0) && m.m_ready;
  assign grant_mask = push ? (N'(1) << grant_idx) : '0;

  // A pending sample that is not leaving this cycle and changes again is lost.
  assign overwrite_any = |(pending & changed & ~grant_mask);

`ifdef SAMPLE_TIMESTAMP_EN
  assign push_rec = {ID_W'(grant_idx), last_word[grant_idx], ts[grant_idx]};
`else
  assign push_rec = {ID_W'(grant_idx), last_word[grant_idx]};
`endif

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LEVEL_W'(1);
      2'b01:   level_next = level - LEVEL_W'(1);
      default: level_next = level;
    endcase
  end

  // Head register: the output fields are registered copies of the FIFO head
  // so they hold their last value once the FIFO drains.
  always_comb begin
    head_load = 1'b0;
    head_next = push_rec;
    if (pop) begin
      if (level > LEVEL_W'(1)) begin
        head_load = 1'b1;
        head_next = mem[rd_ptr + PTR_W'(1)];
      end else if (push) begin
        head_load = 1'b1;
      end
    end else if ((level == '0) && push) begin
      head_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) last_word[i] <= '0;
      pending       <= '0;
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      m.m_valid     <= 1'b0;
      m.m_id        <= '0;
      m.m_data      <= '0;
      m.overwrite_o <= 1'b0;
`ifdef SAMPLE_TIMESTAMP_EN
      ts_cnt        <= '0;
      for (int i = 0; i < N; i++) ts[i] <= '0;
      m.m_ts        <= '0;
`endif
    end else begin
      for (int i = 0; i < N; i++) last_word[i] <= sensor_data[32*i +: 32];
      // A change in the grant cycle re-arms the bit: set wins over clear.
      pending       <= (pending & ~grant_mask) | changed;
      m.overwrite_o <= overwrite_any;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= (grant_idx == RR_W'(N-1)) ? '0 : grant_idx + RR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      level     <= level_next;
      m.m_valid <= (level_next != '0);
      if (head_load) begin
        m.m_id   <= head_next[REC_W-1 -: ID_W];
        m.m_data <= head_next[REC_W-ID_W-1 -: 32];
`ifdef SAMPLE_TIMESTAMP_EN
        m.m_ts   <= head_next[31:0];
`endif
      end
`ifdef SAMPLE_TIMESTAMP_EN
      ts_cnt <= ts_cnt + 32'd1;
      for (int i = 0; i < N; i++) begin
        if (changed[i]) ts[i] <= ts_cnt;
      end
`endif
    end
  end

  assign m.fifo_level = level;

endmodule

// File: tb/tb_lighthouse_sample_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lighthouse_sample_arbiter
//   Directed scenarios followed by randomized traffic, all compared against a
//   queue-based reference model of the arbiter's record stream.
// ---------------------------------------------------------------------------
module tb_lighthouse_sample_arbiter;

  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int ID_W    = 10;
  localparam int LEVEL_W = 3;
`ifdef SAMPLE_TIMESTAMP_EN
  localparam int REC_W   = ID_W + 64;
`else
  localparam int REC_W   = ID_W + 32;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [32*N-1:0]  sensor_data;

  always #5 clk = ~clk;

  lighthouse_sample_arbiter_if #(.ID_W(ID_W), .LEVEL_W(LEVEL_W)) bus ();

  lighthouse_sample_arbiter #(
    .NUMBER_OF_SENSORS (N),
    .FIFO_DEPTH        (DEPTH),
    .ID_W              (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_data (sensor_data),
    .m           (bus)
  );

  // ---------------- scoreboard / reference model ----------------
  int                checks   = 0;
  int                failures = 0;

  logic [REC_W-1:0]  exp_q[$];
  logic [31:0]       mdl_last [N];
  bit                mdl_pend [N];
  int                mdl_rr;
  logic [ID_W-1:0]   exp_id;
  logic [31:0]       exp_data;
  logic              exp_ovw;
`ifdef SAMPLE_TIMESTAMP_EN
  logic [31:0]       mdl_cnt;
  logic [31:0]       mdl_ts [N];
`endif

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the arbiter as the behaviour describes it.
  task automatic model_step();
    bit               granted;
    bit               do_pop;
    bit               ch;
    int               k;
    int               c;
    logic [31:0]      w;
    logic [REC_W-1:0] rec;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        mdl_last[i] = '0;
        mdl_pend[i] = 1'b0;
`ifdef SAMPLE_TIMESTAMP_EN
        mdl_ts[i]   = '0;
`endif
      end
`ifdef SAMPLE_TIMESTAMP_EN
      mdl_cnt  = '0;
`endif
      mdl_rr   = 0;
      exp_id   = '0;
      exp_data = '0;
      exp_ovw  = 1'b0;
    end else begin
      do_pop  = (exp_q.size() > 0) && bus.m_ready;
      granted = 1'b0;
      k       = 0;
      rec     = '0;
      if (exp_q.size() < DEPTH) begin
        for (int j = 0; j < N; j++) begin
          c = (mdl_rr + j) % N;
          if (!granted && mdl_pend[c]) begin
            granted = 1'b1;
            k       = c;
          end
        end
      end
      if (granted) begin
`ifdef SAMPLE_TIMESTAMP_EN
        rec = {ID_W'(k), mdl_last[k], mdl_ts[k]};
`else
        rec = {ID_W'(k), mdl_last[k]};
`endif
      end
      exp_ovw = 1'b0;
      for (int i = 0; i < N; i++) begin
        w  = sensor_data[32*i +: 32];
        ch = (w != mdl_last[i]);
        if (ch && mdl_pend[i] && !(granted && k == i)) exp_ovw = 1'b1;
        if (granted && k == i) mdl_pend[i] = 1'b0;
        if (ch) begin
          mdl_pend[i] = 1'b1;
`ifdef SAMPLE_TIMESTAMP_EN
          mdl_ts[i]   = mdl_cnt;
`endif
        end
        mdl_last[i] = w;
      end
`ifdef SAMPLE_TIMESTAMP_EN
      mdl_cnt = mdl_cnt + 32'd1;
`endif
      if (do_pop) void'(exp_q.pop_front());
      if (granted) begin
        exp_q.push_back(rec);
        mdl_rr = (k + 1) % N;
      end
      if (exp_q.size() > 0) begin
        exp_id   = exp_q[0][REC_W-1 -: ID_W];
        exp_data = exp_q[0][REC_W-ID_W-1 -: 32];
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("m_valid",    64'(bus.m_valid),    64'(exp_q.size() != 0));
    check_eq("fifo_level", 64'(bus.fifo_level), 64'(exp_q.size()));
    check_eq("overwrite",  64'(bus.overwrite_o), 64'(exp_ovw));
    check_eq("m_id",       64'(bus.m_id),       64'(exp_id));
    check_eq("m_data",     64'(bus.m_data),     64'(exp_data));
`ifdef SAMPLE_TIMESTAMP_EN
    if (exp_q.size() != 0) check_eq("m_ts", 64'(bus.m_ts), 64'(exp_q[0][31:0]));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge; the model and DUT see them at the
  // rising edge; outputs are sampled at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_sensor(input int i, input logic [31:0] w);
    sensor_data[32*i +: 32] = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    sensor_data = '0;
    bus.m_ready = 1'b0;
    cycle();
    cycle();
    check_eq("rst_valid", 64'(bus.m_valid), 64'd0);
    check_eq("rst_level", 64'(bus.fifo_level), 64'd0);
    rst = 1'b0;

    // Quiet inputs: nothing is produced.
    repeat (10) cycle();
    check_eq("idle_valid", 64'(bus.m_valid), 64'd0);
    check_eq("idle_level", 64'(bus.fifo_level), 64'd0);

    // Single change: record visible two edges later.
    set_sensor(2, 32'h0001_2345);
    cycle();
    check_eq("lat_early_valid", 64'(bus.m_valid), 64'd0);
    cycle();
    check_eq("lat_valid", 64'(bus.m_valid), 64'd1);
    check_eq("lat_id",    64'(bus.m_id), 64'd2);
    check_eq("lat_data",  64'(bus.m_data), 64'h0001_2345);
    bus.m_ready = 1'b1;
    cycle();
    check_eq("pop_level", 64'(bus.fifo_level), 64'd0);
    bus.m_ready = 1'b0;

    // All sensors change together from a fresh round-robin pointer.
    sensor_data = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_sensor(i, 32'hA000_0000 + 32'(i));
    cycle();
    check_eq("burst_level0", 64'(bus.fifo_level), 64'd0);
    for (int i = 0; i < N; i++) begin
      cycle();
      check_eq("burst_level", 64'(bus.fifo_level), 64'(i + 1));
    end
    check_eq("burst_head_id", 64'(bus.m_id), 64'd0);

    // Full FIFO: sensor 1 changes twice, second change supersedes the first.
    set_sensor(1, 32'h0000_00B1);
    cycle();
    check_eq("ovw_first", 64'(bus.overwrite_o), 64'd0);
    set_sensor(1, 32'h0000_00B2);
    cycle();
    check_eq("ovw_pulse", 64'(bus.overwrite_o), 64'd1);
    cycle();
    check_eq("ovw_clear", 64'(bus.overwrite_o), 64'd0);
    check_eq("full_level", 64'(bus.fifo_level), 64'd4);
    bus.m_ready = 1'b1;
    cycle();
    bus.m_ready = 1'b0;
    check_eq("full_pop_level", 64'(bus.fifo_level), 64'd3);
    cycle();
    check_eq("refill_level", 64'(bus.fifo_level), 64'd4);
    bus.m_ready = 1'b1;
    repeat (3) cycle();
    check_eq("newest_id",   64'(bus.m_id), 64'd1);
    check_eq("newest_data", 64'(bus.m_data), 64'h0000_00B2);
    cycle();
    check_eq("drain_level", 64'(bus.fifo_level), 64'd0);

    // Pointer wrap: after sensor 3 is granted, sensor 0 goes before sensor 3.
    set_sensor(3, 32'h0000_00C3);
    cycle();
    cycle();
    check_eq("wrap_s3_id", 64'(bus.m_id), 64'd3);
    set_sensor(0, 32'h0000_00D0);
    set_sensor(3, 32'h0000_00D3);
    cycle();
    bus.m_ready = 1'b0;
    cycle();
    check_eq("wrap_first_id",   64'(bus.m_id), 64'd0);
    check_eq("wrap_first_data", 64'(bus.m_data), 64'h0000_00D0);
    cycle();
    check_eq("wrap_level", 64'(bus.fifo_level), 64'd2);

    // Reset mid-transfer with three records stored.
    set_sensor(1, 32'h0000_00E1);
    cycle();
    cycle();
    check_eq("pre_rst_level", 64'(bus.fifo_level), 64'd3);
    bus.m_ready = 1'b1;
    rst         = 1'b1;
    sensor_data = '0;
    cycle();
    check_eq("mid_rst_valid", 64'(bus.m_valid), 64'd0);
    check_eq("mid_rst_level", 64'(bus.fifo_level), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      cycle();
      check_eq("post_rst_level", 64'(bus.fifo_level), 64'd0);
    end

    // Randomized traffic: small word pool so repeats and overwrites occur.
    for (int c = 0; c < 3000; c++) begin
      if ((c / 200) % 2 == 1) bus.m_ready = ($urandom_range(0, 3) == 0);
      else                    bus.m_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) set_sensor(i, 32'($urandom_range(0, 3)) << (8 * i));
      end
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
